// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and tag helpers for the fetch/data SRAM port arbiter.
package mem_port_arbiter_pkg;

  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

  localparam int TAG_VALID = 0;
  localparam int TAG_OWNER = 1;
  localparam int TAG_WRITE = 2;
  localparam int TAG_W     = 3;

  function automatic logic [TAG_W-1:0] make_tag(input logic valid, input logic owner,
                                                input logic is_write);
    make_tag = '0;
    make_tag[TAG_VALID] = valid;
    make_tag[TAG_OWNER] = owner;
    make_tag[TAG_WRITE] = is_write;
  endfunction

  // A redirect invalidates fetch entries only; data entries keep flowing.
  function automatic logic [TAG_W-1:0] kill_clear(input logic [TAG_W-1:0] tag, input logic kill);
    kill_clear = tag;
    if (kill && tag[TAG_OWNER] == OWN_FETCH) kill_clear[TAG_VALID] = 1'b0;
  endfunction

endpackage

// File: rtl/arb_tag_pipe.sv
// Owner-tag shift register matching the SRAM read latency; fetch entries
// can be invalidated in flight by a redirect.
module arb_tag_pipe
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             kill_fetch,
  input  logic [TAG_W-1:0] tag_in,
  output logic [TAG_W-1:0] tag_out
);

  logic [TAG_W-1:0] stage [MEM_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_LAT; i++) stage[i] <= '0;
    end else begin
      stage[0] <= kill_clear(tag_in, kill_fetch);
      for (int i = 1; i < MEM_LAT; i++) stage[i] <= kill_clear(stage[i-1], kill_fetch);
    end
  end

  assign tag_out = stage[MEM_LAT-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port SRAM between fetch and load/store, with a
// starvation guard for fetch and fixed-latency response routing.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [DATA_W-1:0] i_addr,
  input  logic              i_kill,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [DATA_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [STRB_W-1:0] d_wstrb,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic [STRB_W-1:0] mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0]       starve_cnt;
  logic             fetch_ok;
  logic [TAG_W-1:0] tag_in;
  logic [TAG_W-1:0] tag_out;
  logic             exit_valid;

  assign fetch_ok = i_req && !i_kill;

  // Grants are gated by rst_n so nothing reaches the SRAM while in reset.
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (rst_n) begin
      if (starve_cnt == STARVE_LIM && fetch_ok) i_gnt = 1'b1;
      else if (d_req)                           d_gnt = 1'b1;
      else if (fetch_ok)                        i_gnt = 1'b1;
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = '0;
    if (i_gnt) begin
      mem_addr = i_addr;
    end else if (d_gnt) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      if (d_we) mem_we = d_wstrb;
    end
  end

  assign mem_en = i_gnt | d_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                       starve_cnt <= '0;
    else if (!i_req || i_gnt)                         starve_cnt <= '0;
    else if (d_gnt && starve_cnt != STARVE_LIM)       starve_cnt <= starve_cnt + 4'd1;
  end

  assign tag_in = make_tag(mem_en, d_gnt ? OWN_DATA : OWN_FETCH, d_gnt && d_we);

  arb_tag_pipe #(.MEM_LAT(MEM_LAT)) u_tag_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .kill_fetch (i_kill),
    .tag_in     (tag_in),
    .tag_out    (tag_out)
  );

  // A fetch leaving the pipe in the same cycle as a redirect is also dropped.
  assign exit_valid = tag_out[TAG_VALID];
  assign i_rvalid   = exit_valid && tag_out[TAG_OWNER] == OWN_FETCH && !i_kill;
  assign d_rvalid   = exit_valid && tag_out[TAG_OWNER] == OWN_DATA;
  assign i_rdata    = i_rvalid ? mem_rdata : '0;
  assign d_rdata    = (d_rvalid && !tag_out[TAG_WRITE]) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: two arbiters (MEM_LAT 1 and 3) share stimulus; each has
// its own SRAM read pipeline over one shared memory array.
module tb_mem_port_arbiter;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        i_req = 1'b0, i_kill = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic [3:0]  d_wstrb = '0;

  logic        i_gnt_1, i_rvalid_1, d_gnt_1, d_rvalid_1, mem_en_1;
  logic [31:0] i_rdata_1, d_rdata_1, mem_addr_1, mem_wdata_1, mem_rdata_1;
  logic [3:0]  mem_we_1;
  logic        i_gnt_3, i_rvalid_3, d_gnt_3, d_rvalid_3, mem_en_3;
  logic [31:0] i_rdata_3, d_rdata_3, mem_addr_3, mem_wdata_3, mem_rdata_3;
  logic [3:0]  mem_we_3;

  logic [31:0] mem_arr [256];
  logic [31:0] rp1;
  logic [31:0] rp3 [3];

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  logic mon_en = 1'b0;
  exp_t q_i1[$], q_d1[$], q_i3[$], q_d3[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .i_req(i_req), .i_addr(i_addr), .i_kill(i_kill),
    .i_gnt(i_gnt_1), .i_rvalid(i_rvalid_1), .i_rdata(i_rdata_1),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_gnt(d_gnt_1), .d_rvalid(d_rvalid_1), .d_rdata(d_rdata_1),
    .mem_en(mem_en_1), .mem_we(mem_we_1), .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1),
    .mem_rdata(mem_rdata_1)
  );

  mem_port_arbiter #(.MEM_LAT(3), .STARVE_MAX(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .i_req(i_req), .i_addr(i_addr), .i_kill(i_kill),
    .i_gnt(i_gnt_3), .i_rvalid(i_rvalid_3), .i_rdata(i_rdata_3),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_gnt(d_gnt_3), .d_rvalid(d_rvalid_3), .d_rdata(d_rdata_3),
    .mem_en(mem_en_3), .mem_we(mem_we_3), .mem_addr(mem_addr_3), .mem_wdata(mem_wdata_3),
    .mem_rdata(mem_rdata_3)
  );

  // Word i holds 0x1000_0000 + byte address, so expected reads are easy to derive.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem_arr[i] <= 32'h1000_0000 + 32'(i * 4);
    end else if (mem_en_1) begin
      for (int b = 0; b < 4; b++)
        if (mem_we_1[b]) mem_arr[mem_addr_1[9:2]][8*b +: 8] <= mem_wdata_1[8*b +: 8];
    end
    rp1    <= mem_arr[mem_addr_1[9:2]];
    rp3[0] <= mem_arr[mem_addr_3[9:2]];
    rp3[1] <= rp3[0];
    rp3[2] <= rp3[1];
  end

  assign mem_rdata_1 = rp1;
  assign mem_rdata_3 = rp3[2];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic ir, input logic [31:0] ia, input logic ik,
                               input logic dr, input logic dw, input logic [31:0] da,
                               input logic [31:0] dd, input logic [3:0] ds);
    @(posedge clk);
    #1;
    i_req = ir; i_addr = ia; i_kill = ik;
    d_req = dr; d_we = dw; d_addr = da; d_wdata = dd; d_wstrb = ds;
  endtask

  task automatic checkOutput(input logic eig, input logic edg, input logic [31:0] eaddr,
                             input logic [3:0] ewe, input logic [31:0] ewd);
    @(negedge clk);
    cmp("l1.i_gnt",     32'(i_gnt_1),  32'(eig));
    cmp("l1.d_gnt",     32'(d_gnt_1),  32'(edg));
    cmp("l1.mem_en",    32'(mem_en_1), 32'(eig | edg));
    cmp("l1.mem_we",    32'(mem_we_1), 32'(ewe));
    cmp("l1.mem_addr",  mem_addr_1,    eaddr);
    cmp("l1.mem_wdata", mem_wdata_1,   ewd);
    cmp("l3.i_gnt",     32'(i_gnt_3),  32'(eig));
    cmp("l3.d_gnt",     32'(d_gnt_3),  32'(edg));
    cmp("l3.mem_en",    32'(mem_en_3), 32'(eig | edg));
    cmp("l3.mem_we",    32'(mem_we_3), 32'(ewe));
    cmp("l3.mem_addr",  mem_addr_3,    eaddr);
    cmp("l3.mem_wdata", mem_wdata_3,   ewd);
  endtask

  task automatic check_zero();
    cmp("rst.l1.i_gnt",    32'(i_gnt_1),    32'h0);
    cmp("rst.l1.d_gnt",    32'(d_gnt_1),    32'h0);
    cmp("rst.l1.i_rvalid", 32'(i_rvalid_1), 32'h0);
    cmp("rst.l1.d_rvalid", 32'(d_rvalid_1), 32'h0);
    cmp("rst.l1.i_rdata",  i_rdata_1,       32'h0);
    cmp("rst.l1.d_rdata",  d_rdata_1,       32'h0);
    cmp("rst.l1.mem_en",   32'(mem_en_1),   32'h0);
    cmp("rst.l1.mem_we",   32'(mem_we_1),   32'h0);
    cmp("rst.l1.mem_addr", mem_addr_1,      32'h0);
    cmp("rst.l1.mem_wd",   mem_wdata_1,     32'h0);
    cmp("rst.l3.i_gnt",    32'(i_gnt_3),    32'h0);
    cmp("rst.l3.d_gnt",    32'(d_gnt_3),    32'h0);
    cmp("rst.l3.i_rvalid", 32'(i_rvalid_3), 32'h0);
    cmp("rst.l3.d_rvalid", 32'(d_rvalid_3), 32'h0);
    cmp("rst.l3.i_rdata",  i_rdata_3,       32'h0);
    cmp("rst.l3.d_rdata",  d_rdata_3,       32'h0);
    cmp("rst.l3.mem_en",   32'(mem_en_3),   32'h0);
    cmp("rst.l3.mem_we",   32'(mem_we_3),   32'h0);
    cmp("rst.l3.mem_addr", mem_addr_3,      32'h0);
    cmp("rst.l3.mem_wd",   mem_wdata_3,     32'h0);
  endtask

  task automatic push_fetch(input logic [31:0] data, input logic on1, input logic on3);
    exp_t e;
    e.data = data;
    if (on1) begin e.due = cyc + 1; q_i1.push_back(e); end
    if (on3) begin e.due = cyc + 3; q_i3.push_back(e); end
  endtask

  task automatic push_data(input logic [31:0] data, input logic on1, input logic on3);
    exp_t e;
    e.data = data;
    if (on1) begin e.due = cyc + 1; q_d1.push_back(e); end
    if (on3) begin e.due = cyc + 3; q_d3.push_back(e); end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      checkOutput(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    end
  endtask

  task automatic chk_rsp(input string name, input logic v, input logic [31:0] d, input int which);
    exp_t e;
    int   sz;
    if (v === 1'b0) begin
      cmp({name, ".idle_rdata"}, d, 32'h0);
      return;
    end
    case (which)
      0:       sz = q_i1.size();
      1:       sz = q_d1.size();
      2:       sz = q_i3.size();
      default: sz = q_d3.size();
    endcase
    total++;
    if (sz == 0) begin
      bad++;
      $display("[TB] FAIL %s: unexpected rvalid=%b data %h at cycle %0d", name, v, d, cyc);
      return;
    end
    case (which)
      0:       e = q_i1.pop_front();
      1:       e = q_d1.pop_front();
      2:       e = q_i3.pop_front();
      default: e = q_d3.pop_front();
    endcase
    if (d !== e.data || cyc != e.due) begin
      bad++;
      $display("[TB] FAIL %s: got %h at cycle %0d, expected %h at cycle %0d",
               name, d, cyc, e.data, e.due);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk_rsp("l1.i_rsp", i_rvalid_1, i_rdata_1, 0);
      chk_rsp("l1.d_rsp", d_rvalid_1, d_rdata_1, 1);
      chk_rsp("l3.i_rsp", i_rvalid_3, i_rdata_3, 2);
      chk_rsp("l3.d_rsp", d_rvalid_3, d_rdata_3, 3);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Reset with both requesters active: grants must stay low.
    #1;
    rst_n = 1'b0;
    i_req = 1'b1; i_addr = 32'h4; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h8; d_wstrb = 4'hF;
    #2;
    check_zero();
    repeat (2) @(posedge clk);
    #1;
    i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wstrb = '0;
    rst_n = 1'b1;
    mon_en = 1'b1;

    $display("[TB] fetch stream");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 32'(k * 4), 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      checkOutput(1'b1, 1'b0, 32'(k * 4), 4'h0, 32'h0);
      push_fetch(32'h1000_0000 + 32'(k * 4), 1'b1, 1'b1);
    end
    idle(4);

    $display("[TB] contention");
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, 32'h20, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
      if (k % 5 == 4) begin
        checkOutput(1'b1, 1'b0, 32'h20, 4'h0, 32'h0);
        push_fetch(32'h1000_0020, 1'b1, 1'b1);
      end else begin
        checkOutput(1'b0, 1'b1, 32'h100, 4'h0, 32'h0);
        push_data(32'h1000_0100, 1'b1, 1'b1);
      end
    end
    idle(4);

    $display("[TB] store then load");
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h40, 32'hAABB_CCDD, 4'b0011);
    checkOutput(1'b0, 1'b1, 32'h40, 4'b0011, 32'hAABB_CCDD);
    push_data(32'h0, 1'b1, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h40, 32'h1234_5678, 4'hF);
    checkOutput(1'b0, 1'b1, 32'h40, 4'h0, 32'h1234_5678);
    push_data(32'h1000_CCDD, 1'b1, 1'b1);
    idle(4);

    $display("[TB] redirect kill");
    applyStimulus(1'b1, 32'h8, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    checkOutput(1'b1, 1'b0, 32'h8, 4'h0, 32'h0);
    push_fetch(32'h1000_0008, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'hC, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    checkOutput(1'b1, 1'b0, 32'hC, 4'h0, 32'h0);
    applyStimulus(1'b1, 32'h10, 1'b1, 1'b1, 1'b0, 32'h44, 32'h0, 4'h0);
    checkOutput(1'b0, 1'b1, 32'h44, 4'h0, 32'h0);
    push_data(32'h1000_0044, 1'b1, 1'b1);
    idle(5);

    $display("[TB] reset with reads in flight");
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    checkOutput(1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
    push_fetch(32'h1000_0000, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
    checkOutput(1'b0, 1'b1, 32'h4, 4'h0, 32'h0);
    applyStimulus(1'b1, 32'h8, 1'b0, 1'b1, 1'b0, 32'hC, 32'h0, 4'h0);
    #1;
    rst_n = 1'b0;
    #1;
    check_zero();
    repeat (2) @(posedge clk);
    #1;
    i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_addr = '0;
    rst_n = 1'b1;
    idle(6);

    cmp("q_i1.empty", 32'(q_i1.size()), 32'h0);
    cmp("q_d1.empty", 32'(q_d1.size()), 32'h0);
    cmp("q_i3.empty", 32'(q_i3.size()), 32'h0);
    cmp("q_d3.empty", 32'(q_d3.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
